// File: rtl/pipe_pkg.sv
// Shared pipeline types and defaults for the IF->ID fetch queue.
// Entry layout and the push/pop operation encoding used by the queue control.
package pipe_pkg;

  localparam int PIPE_XLEN        = 32;
  localparam int FQ_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [PIPE_XLEN-1:0] pc;
    logic [PIPE_XLEN-1:0] npc;
    logic [PIPE_XLEN-1:0] ir;
  } fetch_entry_t;

  // Bit 0 = push, bit 1 = pop; SWAP keeps occupancy while both pointers advance.
  typedef enum logic [1:0] {
    FQ_HOLD = 2'b00,
    FQ_PUSH = 2'b01,
    FQ_POP  = 2'b10,
    FQ_SWAP = 2'b11
  } fq_op_e;

  function automatic fq_op_e fq_op(input logic push, input logic pop);
    return fq_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/if_id_fetch_queue_ctrl.sv
// Pointer and occupancy control for the fetch queue.
// Decides push/pop from the registered count; a taken branch clears everything.
module if_id_fetch_queue_ctrl
  import pipe_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEFAULT,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_valid,
  input  logic          flush,
  input  logic          id_ready,
  output logic          push,
  output logic          pop,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr_next,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_next,
  output logic          full
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          empty;

  assign full  = (count_reg == FULL_COUNT);
  assign empty = (count_reg == '0);

  // Push is refused while full even if a pop frees a slot the same cycle.
  assign push = fetch_valid && !full && !flush;
  assign pop  = id_ready && !empty && !flush;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      unique case (fq_op(push, pop))
        FQ_PUSH: begin
          wr_ptr_next = wr_ptr_reg + PW'(1);
          count_next  = count_reg + CW'(1);
        end
        FQ_POP: begin
          rd_ptr_next = rd_ptr_reg + PW'(1);
          count_next  = count_reg - CW'(1);
        end
        FQ_SWAP: begin
          wr_ptr_next = wr_ptr_reg + PW'(1);
          rd_ptr_next = rd_ptr_reg + PW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  assign wr_ptr = wr_ptr_reg;
  assign count  = count_reg;

  a_count_bound: assert property (@(posedge clk) disable iff (!rst) count_reg <= FULL_COUNT);

endmodule

// File: rtl/if_id_fetch_queue.sv
// Fetch queue between IF and ID: buffers {PC, NPC, IR} and presents the oldest
// entry to decode through a registered head; flushed by a taken branch in EX.
module if_id_fetch_queue
  import pipe_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEFAULT,
  parameter int XLEN  = PIPE_XLEN,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_PC_in,
  input  logic [XLEN-1:0] if_NPC_in,
  input  logic [XLEN-1:0] if_IR_in,
  input  logic            if_valid_inst_in,
  input  logic            ex_take_branch_in,
  input  logic            id_ready_in,
  output logic            if_stall_out,
  output logic [XLEN-1:0] id_PC_out,
  output logic [XLEN-1:0] id_NPC_out,
  output logic [XLEN-1:0] id_IR_out,
  output logic            id_valid_inst_out,
  output logic [CW-1:0]   fq_count_out
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] ir;
  } entry_t;

  entry_t mem [DEPTH];

  entry_t        wr_entry;
  entry_t        head_reg, head_next;
  logic          head_valid_reg, head_valid_next;
  logic          push, pop, full;
  logic [PW-1:0] wr_ptr, rd_ptr_next;
  logic [CW-1:0] count, count_next;

  if_id_fetch_queue_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .fetch_valid (if_valid_inst_in),
    .flush       (ex_take_branch_in),
    .id_ready    (id_ready_in),
    .push        (push),
    .pop         (pop),
    .wr_ptr      (wr_ptr),
    .rd_ptr_next (rd_ptr_next),
    .count       (count),
    .count_next  (count_next),
    .full        (full)
  );

  assign wr_entry = '{pc: if_PC_in, npc: if_NPC_in, ir: if_IR_in};

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // The new head is the word being written only when the queue is otherwise
  // drained after this cycle's pop; a full queue never accepts a push.
  always_comb begin
    head_next       = '0;
    head_valid_next = 1'b0;
    if (count_next != '0) begin
      head_valid_next = 1'b1;
      if (push && (rd_ptr_next == wr_ptr)) begin
        head_next = wr_entry;
      end else begin
        head_next = mem[rd_ptr_next];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg       <= '0;
      head_valid_reg <= 1'b0;
    end else begin
      head_reg       <= head_next;
      head_valid_reg <= head_valid_next;
    end
  end

  assign id_PC_out         = head_reg.pc;
  assign id_NPC_out        = head_reg.npc;
  assign id_IR_out         = head_reg.ir;
  assign id_valid_inst_out = head_valid_reg;
  assign if_stall_out      = full;
  assign fq_count_out      = count;

  a_no_push_stalled: assert property (@(posedge clk) disable iff (!rst) if_stall_out |-> !push);
  a_valid_matches:   assert property (@(posedge clk) disable iff (!rst)
                                      id_valid_inst_out == (fq_count_out != '0));

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Directed and randomized checks of the IF->ID fetch queue against a queue-based
// model of the occupancy and head-of-queue rules.
module tb_if_id_fetch_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] ir;
  } ent_t;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in, npc_in, ir_in;
  logic        valid_in, br_in, ready_in;
  logic        stall;
  logic [31:0] id_pc, id_npc, id_ir;
  logic        id_valid;
  logic [2:0]  fq_count;

  int total = 0;
  int bad   = 0;

  ent_t model_q[$];

  if_id_fetch_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .if_PC_in          (pc_in),
    .if_NPC_in         (npc_in),
    .if_IR_in          (ir_in),
    .if_valid_inst_in  (valid_in),
    .ex_take_branch_in (br_in),
    .id_ready_in       (ready_in),
    .if_stall_out      (stall),
    .id_PC_out         (id_pc),
    .id_NPC_out        (id_npc),
    .id_IR_out         (id_ir),
    .id_valid_inst_out (id_valid),
    .fq_count_out      (fq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outputs follow directly from what the model queue holds.
  task automatic check_model(input string tag);
    logic [31:0] e_pc, e_npc, e_ir;
    e_pc = 0; e_npc = 0; e_ir = 0;
    if (model_q.size() != 0) begin
      e_pc = model_q[0].pc; e_npc = model_q[0].npc; e_ir = model_q[0].ir;
    end
    chk({tag, ".count"}, 32'(fq_count), 32'(model_q.size()));
    chk({tag, ".valid"}, 32'(id_valid), 32'(model_q.size() != 0));
    chk({tag, ".stall"}, 32'(stall), 32'(model_q.size() == DEPTH));
    chk({tag, ".pc"}, id_pc, e_pc);
    chk({tag, ".npc"}, id_npc, e_npc);
    chk({tag, ".ir"}, id_ir, e_ir);
  endtask

  task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] ir,
                      input bit rdy, input bit br, input string tag);
    bit do_push, do_pop;
    ent_t e;
    valid_in = v; pc_in = pc; npc_in = pc + 32'd4; ir_in = ir;
    ready_in = rdy; br_in = br;
    @(posedge clk);
    if (br) begin
      model_q.delete();
    end else begin
      do_pop  = rdy && (model_q.size() != 0);
      do_push = v && (model_q.size() < DEPTH);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        e.pc = pc; e.npc = pc + 32'd4; e.ir = ir;
        model_q.push_back(e);
      end
    end
    #1;
    $display("cycle %s v=%0d pc=%h rdy=%0d br=%0d -> count=%0d valid=%0d head=%h stall=%0d",
             tag, v, pc, rdy, br, fq_count, id_valid, id_pc, stall);
    check_model(tag);
  endtask

  initial begin
    int pops;
    logic [31:0] next_pc, exp_pop;
    bit rdy;

    rst = 1'b1;
    valid_in = 0; br_in = 0; ready_in = 0;
    pc_in = 0; npc_in = 0; ir_in = 0;
    #2 rst = 1'b0;
    #1;
    check_model("reset");
    @(posedge clk);
    #1 rst = 1'b1;

    // 1: fill with ID stalled
    for (int i = 0; i < 4; i++) step(1, 32'(4 * i), $urandom, 0, 0, "t1.fill");
    chk("t1.count4", 32'(fq_count), 4);
    chk("t1.stall", 32'(stall), 1);
    chk("t1.head", id_pc, 32'h0);

    // 2: full, push refused while a pop happens
    step(1, 32'h10, $urandom, 1, 0, "t2.fullpop");
    chk("t2.head", id_pc, 32'h4);
    chk("t2.count3", 32'(fq_count), 3);
    chk("t2.stall", 32'(stall), 0);

    // 3: steady push+pop at count 2
    step(0, 0, 0, 1, 0, "t3.drain");
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h10 + 32'(4 * i), $urandom, 1, 0, "t3.swap");
      chk("t3.count2", 32'(fq_count), 2);
      chk("t3.head", id_pc, 32'hC + 32'(4 * i));
    end

    // 4: interleaved traffic wrapping the pointers twice; ID must see 0..0x24
    step(0, 0, 0, 0, 1, "t4.flush");
    pops = 0; next_pc = 0; exp_pop = 0;
    for (int c = 0; c < 200 && pops < 10; c++) begin
      rdy = (c % 3) != 0;
      if (rdy && id_valid) begin
        chk("t4.order", id_pc, exp_pop);
        exp_pop += 4;
        pops++;
      end
      if (next_pc <= 32'h24) begin
        if (!stall) begin
          step(1, next_pc, $urandom, rdy, 0, "t4.wrap");
          next_pc += 4;
        end else begin
          step(1, next_pc, $urandom, rdy, 0, "t4.held");
        end
      end else begin
        step(0, 0, 0, rdy, 0, "t4.tail");
      end
    end
    chk("t4.popcount", 32'(pops), 10);

    // 5: flush a full queue; the word fetched alongside is dropped
    for (int i = 0; i < 4; i++) step(1, 32'h40 + 32'(4 * i), $urandom, 0, 0, "t5.fill");
    step(1, 32'h100, $urandom, 0, 1, "t5.flush");
    chk("t5.count0", 32'(fq_count), 0);
    chk("t5.valid0", 32'(id_valid), 0);
    chk("t5.stall0", 32'(stall), 0);
    step(1, 32'h200, $urandom, 0, 0, "t5.target");
    chk("t5.head200", id_pc, 32'h200);
    step(0, 0, 0, 1, 0, "t5.consume");

    // 6: asynchronous reset with three entries queued
    step(0, 0, 0, 0, 1, "t6.flush");
    for (int i = 0; i < 3; i++) step(1, 32'h300 + 32'(4 * i), $urandom, 0, 0, "t6.fill");
    chk("t6.count3", 32'(fq_count), 3);
    #2 rst = 1'b0;
    #1;
    model_q.delete();
    check_model("t6.async");
    valid_in = 0;
    @(posedge clk);
    #1 rst = 1'b1;
    step(1, 32'h0, $urandom, 0, 0, "t6.first");
    chk("t6.head0", id_pc, 32'h0);
    chk("t6.valid", 32'(id_valid), 1);

    // random traffic, several bias settings
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < 150; c++) begin
        step($urandom_range(0, 3) != 0 || ph == 0,
             $urandom & 32'hFFFF_FFFC, $urandom,
             (ph == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0),
             $urandom_range(0, 19) == 0, "rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
